// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one log2 shift step per stage, SLL/SRL/SRA/ROL.
// Valid/ready handshake with a global stall, synchronous flush and a pass-through tag.
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   a;
        logic [1:0]       m;
        logic             s;
        logic [TAG_W-1:0] t;
    } stage_t;

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int               n,
        input logic [1:0]       m,
        input logic             s
    );
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   r;
        ext = {{WIDTH{s}}, d} >> n;
        r   = '0;
        unique case (m)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = ext[WIDTH-1:0];
            default: r = (d << n) | (d >> (WIDTH - n));
        endcase
        return r;
    endfunction

    stage_t head;
    stage_t pipe [SHW];
    logic   stall;

    assign stall     = pipe[SHW-1].v && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = pipe[SHW-1].v;
    assign out_data  = pipe[SHW-1].d;
    assign out_tag   = pipe[SHW-1].t;

    // Sign is captured once at entry so SRA fill survives later stages.
    always_comb begin
        head   = '0;
        head.v = in_valid;
        head.d = in_data;
        head.a = in_shamt;
        head.m = in_mode;
        head.s = in_data[WIDTH-1];
        head.t = in_tag;
    end

    for (genvar k = 0; k < SHW; k++) begin : g_st
        localparam int B = SHW - 1 - k;
        localparam int N = 2 ** B;
        stage_t prv;

        if (k == 0) begin : g_first
            assign prv = head;
        end else begin : g_next
            assign prv = pipe[k-1];
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                pipe[k] <= '0;
            end else if (flush) begin
                pipe[k].v <= 1'b0;
            end else if (!stall) begin
                pipe[k] <= prv;
                if (prv.a[B])
                    pipe[k].d <= shift_step(prv.d, N, prv.m, prv.s);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: vector table, scoreboard queue,
// stall, flush, reset and random streaming with random backpressure.
module tb_pipelined_shifter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    pipelined_shifter #(.WIDTH(32), .SHW(5), .TAG_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        int          c;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic [1:0]  m;
        logic [4:0]  t;
        logic [31:0] e;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rcv = 0;
    bit   lat_on = 1'b0;
    bit   rnd_on = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                              input logic [4:0] a,
                                              input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'd0: r = d << a;
            2'd1: r = d >> a;
            2'd2: r = $unsigned($signed(d) >>> a);
            default: r = (a == 0) ? d : ((d << a) | (d >> (6'd32 - a)));
        endcase
        return r;
    endfunction

    // Output side of the scoreboard
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            rcv++;
            if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data", out_data, e.d);
                chk("tag", {27'd0, out_tag}, {27'd0, e.t});
                if (lat_on)
                    chk("latency", cyc - e.c, 32'd5);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rnd_on)
                out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; leaves in_valid high for back-to-back issue.
    task automatic send(input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] m, input logic [4:0] t,
                        input logic [31:0] e);
        int n;
        exp_t x;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = a;
        in_mode  = m;
        in_tag   = t;
        n = 0;
        forever begin
            @(negedge clock);
            if (in_ready) begin
                x.d = e;
                x.t = t;
                x.c = cyc;
                q.push_back(x);
                @(posedge clock);
                #1;
                break;
            end
            @(posedge clock);
            #1;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        vec_t vt[$];
        int   r0;
        logic [31:0] hd;
        logic [4:0]  ht;
        int   sent;

        vt.push_back('{32'h0000_00FF, 5'd16, 2'd0, 5'd3,  32'h00FF_0000});
        vt.push_back('{32'h8000_0000, 5'd31, 2'd2, 5'd1,  32'hFFFF_FFFF});
        vt.push_back('{32'h8000_0000, 5'd31, 2'd1, 5'd2,  32'h0000_0001});
        vt.push_back('{32'h8000_0001, 5'd4,  2'd3, 5'd4,  32'h0000_0018});
        vt.push_back('{32'h8000_0001, 5'd31, 2'd3, 5'd6,  32'hC000_0000});
        vt.push_back('{32'h7FFF_FFFF, 5'd31, 2'd2, 5'd7,  32'h0000_0000});
        vt.push_back('{32'h0000_0001, 5'd31, 2'd0, 5'd8,  32'h8000_0000});
        vt.push_back('{32'hF0F0_F0F0, 5'd4,  2'd2, 5'd9,  32'hFF0F_0F0F});
        vt.push_back('{32'hF0F0_F0F0, 5'd4,  2'd1, 5'd10, 32'h0F0F_0F0F});
        vt.push_back('{32'h8765_4321, 5'd0,  2'd0, 5'd11, 32'h8765_4321});
        vt.push_back('{32'h8765_4321, 5'd0,  2'd2, 5'd12, 32'h8765_4321});
        vt.push_back('{32'h8765_4321, 5'd0,  2'd3, 5'd13, 32'h8765_4321});

        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Directed vectors, back to back
        lat_on = 1'b1;
        foreach (vt[i])
            send(vt[i].d, vt[i].a, vt[i].m, vt[i].t, vt[i].e);
        drain();

        // Streaming, shamt 0..31
        r0 = rcv;
        for (int i = 0; i < 32; i++)
            send(32'hA5C3_0F81, 5'(i), 2'(i % 4), 5'(i),
                 ref_shift(32'hA5C3_0F81, 5'(i), 2'(i % 4)));
        drain();
        chk("stream_count", rcv - r0, 32'd32);
        lat_on = 1'b0;

        // Backpressure mid-stream
        r0 = rcv;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h1234_5678 + i, 5'(3 * i), 2'(i % 4), 5'(20 + i),
                         ref_shift(32'h1234_5678 + i, 5'(3 * i), 2'(i % 4)));
                in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (!out_valid && n < 50);
                @(posedge clock);
                #1;
                out_ready = 1'b0;
                @(negedge clock);
                hd = out_data;
                ht = out_tag;
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                repeat (2) begin
                    @(negedge clock);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_data", out_data, hd);
                    chk("stall_tag", {27'd0, out_tag}, {27'd0, ht});
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", rcv - r0, 32'd8);

        // Flush with a concurrent input
        r0 = rcv;
        for (int i = 0; i < 3; i++)
            send(32'hDEAD_BEEF, 5'(i + 1), 2'd0, 5'(i), 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0BAD_0BAD;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clock);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (7) @(negedge clock);
        chk("flush_no_out", rcv - r0, 32'd0);
        @(posedge clock);
        #1;
        lat_on = 1'b1;
        send(32'h0000_0F00, 5'd8, 2'd1, 5'd17, 32'h0000_000F);
        drain();
        lat_on = 1'b0;
        chk("flush_after", rcv - r0, 32'd1);

        // Reset with ops in flight and the output blocked
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'hCAFE_0000 + i, 5'd1, 2'd0, 5'(i), 32'd0);
        idle(3);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        q.delete();
        @(negedge clock);
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst2_out_data", out_data, 32'd0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;

        // Random ops with random backpressure
        r0 = rcv;
        sent = 0;
        rnd_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] d;
            logic [4:0]  a;
            logic [1:0]  m;
            d = $urandom;
            a = 5'($urandom_range(0, 31));
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                idle(1);
            send(d, a, m, 5'(i), ref_shift(d, a, m));
            sent++;
        end
        drain();
        rnd_on = 1'b0;
        out_ready = 1'b1;
        chk("random_count", rcv - r0, sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
